// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and helpers for the FIFO write arbiter
package fifo_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;

  // Modulo increment with an explicit wrap so non-power-of-2 counts work.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rtl/fifo_wr_arbiter_rr_pick.sv - combinational round-robin picker starting at ptr
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  input  logic [N-1:0]   mask,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] idx,
  output logic           any
);

  always_comb begin : pick
    int c;
    logic [IDW-1:0] ci;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    c   = 0;
    ci  = '0;
    for (int k = 0; k < N; k++) begin
      c = int'(ptr) + k;
      if (c >= N) c = c - N;
      ci = IDW'(c);
      if (!any && req[ci] && mask[ci]) begin
        any     = 1'b1;
        gnt[ci] = 1'b1;
        idx     = ci;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin write-port arbiter in front of a FIFO
// Packet lock is compiled in with FIFO_WR_ARB_LOCK_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int WIDTH   = 32,
  parameter  int NUM_REQ = 4,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic                     clk_i,
  input  logic                     arst_ni,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]       req_last_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  output logic                     wen_o,
  output logic [WIDTH-1:0]         wdata_o,
  output logic [IDW-1:0]           wid_o,
  input  logic                     full_i,
  input  logic                     almost_full_i,
  output logic                     locked_o
);

  arb_state_e         state_q, state_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]     owner_q, owner_d;
  logic [NUM_REQ-1:0] mask, gnt;
  logic [IDW-1:0]     idx;
  logic               any, allow, xfer;

  // wen_o is a write the FIFO has not yet counted, so almost-full already means full.
  assign allow = !full_i && !(wen_o && almost_full_i);

  assign mask = (state_q == ARB_LOCKED) ? (NUM_REQ'(1) << owner_q) : '1;

  rr_pick #(.N(NUM_REQ), .IDW(IDW)) u_pick (
    .req  (req_valid_i),
    .ptr  (rr_ptr_q),
    .mask (mask),
    .gnt  (gnt),
    .idx  (idx),
    .any  (any)
  );

  assign req_ready_o = (allow && arst_ni) ? gnt : '0;
  assign xfer        = allow && arst_ni && any;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    if (xfer) begin
      unique case (state_q)
        ARB_IDLE: begin
          rr_ptr_d = IDW'(rr_next(32'(idx), NUM_REQ));
`ifdef FIFO_WR_ARB_LOCK_EN
          if (!req_last_i[idx]) begin
            state_d = ARB_LOCKED;
            owner_d = idx;
          end
`endif
        end
        ARB_LOCKED: begin
          if (req_last_i[idx]) begin
            state_d  = ARB_IDLE;
            rr_ptr_d = IDW'(rr_next(32'(owner_q), NUM_REQ));
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q  <= ARB_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      wen_o   <= 1'b0;
      wdata_o <= '0;
      wid_o   <= '0;
    end else begin
      wen_o <= xfer;
      if (xfer) begin
        wdata_o <= req_data_i[idx*WIDTH +: WIDTH];
        wid_o   <= idx;
      end
    end
  end

`ifdef FIFO_WR_ARB_LOCK_EN
  assign locked_o = (state_q == ARB_LOCKED);
`else
  assign locked_o = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed scoreboard bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

  logic         clk = 1'b0;
  logic         arst_n;
  logic [3:0]   valid, last, ready;
  logic [127:0] data;
  logic         wen, full, afull, locked;
  logic [31:0]  wdata;
  logic [1:0]   wid;

  logic [2:0]   valid3, last3, ready3;
  logic [95:0]  data3;
  logic         wen3, locked3;
  logic [31:0]  wdata3;
  logic [1:0]   wid3;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.WIDTH(32), .NUM_REQ(4)) dut (
    .clk_i(clk), .arst_ni(arst_n), .req_valid_i(valid), .req_data_i(data),
    .req_last_i(last), .req_ready_o(ready), .wen_o(wen), .wdata_o(wdata),
    .wid_o(wid), .full_i(full), .almost_full_i(afull), .locked_o(locked)
  );

  fifo_wr_arbiter #(.WIDTH(32), .NUM_REQ(3)) dut3 (
    .clk_i(clk), .arst_ni(arst_n), .req_valid_i(valid3), .req_data_i(data3),
    .req_last_i(last3), .req_ready_o(ready3), .wen_o(wen3), .wdata_o(wdata3),
    .wid_o(wid3), .full_i(1'b0), .almost_full_i(1'b0), .locked_o(locked3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int id, input logic [31:0] d);
    exp_t e;
    e.id   = 4'(id);
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] da(input int i);
    return 32'hA0 + 32'(i);
  endfunction

  // Every FIFO write must match the oldest predicted beat.
  always @(negedge clk) begin
    if (arst_n === 1'b1 && wen === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_extra_write", 32'(wid), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_wid", 32'(wid), 32'(e.id));
        chk("sb_wdata", wdata, e.data);
      end
    end
  end

  initial begin
    int beat;
    int exp_id;
    logic exp_lock;

    arst_n = 1'b0;
    valid  = 4'hF;
    last   = 4'h0;
    full   = 1'b0;
    afull  = 1'b0;
    for (int i = 0; i < 4; i++) data[i*32 +: 32] = da(i);
    valid3 = 3'b000;
    last3  = 3'b000;
    for (int i = 0; i < 3; i++) data3[i*32 +: 32] = 32'hD0 + 32'(i);

    tick();
    tick();
    chk("rst_wen", 32'(wen), 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_wid", 32'(wid), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);

    // All valid, never full: strict rotation.
    arst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #2;
      chk("rot_ready", 32'(ready), 32'(1 << (k % 4)));
      if (k > 0) chk("rot_wen", 32'(wen), 32'd1);
      push(k % 4, da(k % 4));
      tick();
    end
    valid = 4'h0;
    #2;
    chk("rot_last_wen", 32'(wen), 32'd1);
    tick();
    chk("idle_wen", 32'(wen), 32'd0);

    // Single requester streams back-to-back.
    valid = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      data[2*32 +: 32] = 32'hB0 + 32'(k);
      #2;
      chk("solo_ready", 32'(ready), 32'h4);
      push(2, 32'hB0 + 32'(k));
      tick();
    end

    // Backpressure: almost-full with a pending write, then full, then release.
    data[2*32 +: 32] = da(2);
    valid = 4'hF;
    afull = 1'b1;
    #2;
    chk("afull_pending_ready", 32'(ready), 32'd0);
    tick();
    #2;
    chk("afull_nopend_ready", 32'(ready), 32'h8);
    push(3, da(3));
    tick();
    full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("full_wen", 32'(wen), (k == 0) ? 32'd1 : 32'd0);
      #2;
      chk("full_ready", 32'(ready), 32'd0);
      tick();
    end
    full  = 1'b0;
    afull = 1'b0;
    #2;
    chk("resume_ready", 32'(ready), 32'h1);
    push(0, da(0));
    tick();
    valid = 4'h0;
    tick();

    // Requester 1 sends a 3-beat packet while 0 and 3 are also valid.
    beat = 0;
    for (int c = 0; c < 4; c++) begin
      valid = {1'b1, 1'b0, (beat < 3), 1'b1};
      data[1*32 +: 32] = 32'hC0 + 32'(beat);
      last[1] = (beat == 2);
`ifdef FIFO_WR_ARB_LOCK_EN
      exp_id   = (c < 3) ? 1 : 3;
      exp_lock = (c == 1 || c == 2);
`else
      case (c)
        0: exp_id = 1;
        1: exp_id = 3;
        2: exp_id = 0;
        default: exp_id = 1;
      endcase
      exp_lock = 1'b0;
`endif
      #2;
      chk("pkt_locked", 32'(locked), 32'(exp_lock));
      chk("pkt_ready", 32'(ready), 32'(1 << exp_id));
      push(exp_id, (exp_id == 1) ? 32'hC0 + 32'(beat) : da(exp_id));
      if (exp_id == 1) beat++;
      tick();
    end
    valid = 4'h0;
    last  = 4'h0;
    tick();
    tick();

    // Reset while a packet is open.
    valid = 4'b0010;
    data[1*32 +: 32] = 32'hC8;
    #2;
    chk("pre_rst_ready", 32'(ready), 32'h2);
    push(1, 32'hC8);
    tick();
    valid = 4'h0;
    #2;
`ifdef FIFO_WR_ARB_LOCK_EN
    chk("pre_rst_locked", 32'(locked), 32'd1);
`else
    chk("pre_rst_locked", 32'(locked), 32'd0);
`endif
    @(negedge clk);
    #1;
    arst_n = 1'b0;
    valid  = 4'hF;
    #1;
    chk("mid_rst_locked", 32'(locked), 32'd0);
    chk("mid_rst_wen", 32'(wen), 32'd0);
    chk("mid_rst_ready", 32'(ready), 32'd0);
    tick();
    chk("hold_rst_ready", 32'(ready), 32'd0);
    arst_n = 1'b1;
    #2;
    chk("post_rst_ready", 32'(ready), 32'h1);
    push(0, da(0));
    tick();
    valid = 4'h0;
    tick();

    // NUM_REQ=3 rotation must wrap 2 -> 0.
    valid3 = 3'b111;
    for (int k = 0; k < 7; k++) begin
      #2;
      chk("n3_ready", 32'(ready3), 32'(1 << (k % 3)));
      if (k > 0) begin
        chk("n3_wen", 32'(wen3), 32'd1);
        chk("n3_wid", 32'(wid3), 32'((k - 1) % 3));
        chk("n3_wdata", wdata3, 32'hD0 + 32'((k - 1) % 3));
      end
      tick();
    end
    valid3 = 3'b000;
    chk("n3_final_wid", 32'(wid3), 32'd0);
    chk("n3_locked", 32'(locked3), 32'd0);
    tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Single-clock write-side arbiter that shares one FIFO write port among NUM_REQ requesters using round-robin. Each requester presents a valid/ready stream. The arbiter applies FIFO backpressure from full_i/almost_full_i and issues registered write strobes and data into the FIFO. It sits directly in front of the FIFO write port, in the FIFO's write clock domain.

## Interface
Parameters:
- WIDTH, 32, data width of each requester and of the FIFO.
- NUM_REQ, 4, number of requesters, 2..16.
- IDW, $clog2(NUM_REQ), width of requester index (localparam).

Ports:
- clk_i  in  1  clock
- arst_ni  in  1  reset, asynchronous, active-low
- req_valid_i  in  NUM_REQ  per-requester data valid
- req_data_i  in  NUM_REQ*WIDTH  flattened data; requester i occupies bits [i*WIDTH +: WIDTH]
- req_last_i  in  NUM_REQ  last beat of packet (used only with lock feature)
- req_ready_o  out  NUM_REQ  one-hot (or zero) acceptance
- wen_o  out  1  FIFO write strobe, registered
- wdata_o  out  WIDTH  FIFO write data, registered
- wid_o  out  IDW  index of requester whose beat is on wdata_o
- full_i  in  1  FIFO full
- almost_full_i  in  1  FIFO holds at least DEPTH-1 entries
- locked_o  out  1  arbiter is in the LOCKED state

## Operation
- Transfer on requester i occurs when req_valid_i[i] && req_ready_o[i]. At most one ready bit is high per cycle.
- The allow signal is: allow = !full_i && !(wen_o && almost_full_i). This covers the write already in flight on wen_o, which full_i does not yet reflect.
- When allow=0, or while reset is asserted, all req_ready_o bits are 0.
- Round-robin: search starts at rr_ptr and wraps modulo NUM_REQ. The first requester with valid set gets ready. Ready may depend combinationally on valid; valid must not depend on ready.
- After a transfer from i in state IDLE, rr_ptr <= (i+1) mod NUM_REQ. The pointer wrap is explicit, not a power-of-2 truncation, so non-power-of-2 NUM_REQ works.
- On a transfer, at the next edge: wen_o=1, wdata_o=the accepted data, wid_o=i. With no transfer, wen_o=0 and wdata_o/wid_o hold their values.
- States: IDLE and LOCKED. LOCKED is reachable only with the lock feature enabled (see Configuration).
  - IDLE -> LOCKED: on a transfer with req_last_i=0. Set owner <= i.
  - In LOCKED, only the owner may receive ready. Other requesters wait even when allow=1.
  - LOCKED -> IDLE: on the owner's transfer with req_last_i=1. Set rr_ptr <= (owner+1) mod NUM_REQ.
  - In LOCKED with the owner not valid: the arbiter stays LOCKED with no grant.
- Reset values: state IDLE, rr_ptr 0, owner 0, wen_o 0, wdata_o 0, wid_o 0, locked_o 0.
- Reset asserted mid-packet drops the lock immediately. In-flight requester data is not the arbiter's responsibility.

## Timing
- Latency is 1 cycle from the accepting edge to wen_o at the FIFO.
- Sustained throughput is 1 beat/cycle while allow=1.
- Writes never overflow the FIFO: at almost_full_i with a pending wen_o, no grant is issued that cycle.
- When full_i and the pending write both deassert, grants resume on that same cycle.
- Single requester streaming gets 1 beat/cycle. All requesters valid gives strict rotation 0,1,...,NUM_REQ-1,0 (unlocked).

## Configuration
- Macro: FIFO_WR_ARB_LOCK_EN.
- Defined: packet lock as described in Operation. Grant is held from the first beat until the beat with req_last_i=1.
- Undefined: req_last_i is ignored, state is always IDLE, locked_o is tied to 0, and arbitration rotates every beat.

## Structure
- Package fifo_arb_pkg contains:
  - typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;
  - function rr_next(ptr, n), implementing modulo increment.
- Sub-module rr_pick:
  - Purely combinational.
  - Inputs: req vector, rr_ptr, mask.
  - Outputs: one-hot grant, index, any.
  - The top level owns the state machine, rr_ptr, owner and the output registers.

## Test plan
- NUM_REQ=4, all valid, data=0xA0+i, FIFO never full -> wid_o sequence 0,1,2,3,0; wen_o high every cycle after the first; wdata_o 0xA0..0xA3.
- Only requester 2 valid for 5 cycles -> 5 consecutive writes with wid_o=2; rr_ptr ends at 3.
- almost_full_i=1 with wen_o=1 -> ready=0 that cycle; full_i=1 for 3 cycles -> no ready and wen_o=0; full_i drops -> grant on the same cycle.
- NUM_REQ=3, all valid -> rotation wraps 2->0, never index 3.
- With the lock macro defined: requester 1 sends a 3-beat packet (last on beat 3) while 0 and 3 are valid -> wid_o 1,1,1 then 3; locked_o high for beats 1-2. Without the macro -> wid_o 1,3,0,1.
- arst_ni asserted in LOCKED -> locked_o=0, wen_o=0, all ready 0. After release, the first grant goes to requester 0.
